// File: rtl/ccb_arb_pkg.sv
// rtl/ccb_arb_pkg.sv - shared types, defaults and id-width helper for the CCB access arbiter
package ccb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Defaults also consumed by the CCB mux so both sides agree on agent count.
  localparam int CCB_N_AGENTS_DEF   = 2;
  localparam int CCB_FIFO_DEPTH_DEF = 4;
  localparam int CCB_MAX_HOLD_DEF   = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccb_req_fifo.sv
// rtl/ccb_req_fifo.sv - single-push/single-pop synchronous id queue with count and flags
module ccb_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccb_access_arbiter.sv
// rtl/ccb_access_arbiter.sv - arrival-order CCB arbiter; optional grant watchdog via CCB_ARB_TIMEOUT_EN
module ccb_access_arbiter
  import ccb_arb_pkg::*;
#(
  parameter int N_AGENTS   = CCB_N_AGENTS_DEF,
  parameter int FIFO_DEPTH = CCB_FIFO_DEPTH_DEF,
  parameter int MAX_HOLD   = CCB_MAX_HOLD_DEF,
  localparam int ID_W  = id_width(N_AGENTS),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                fastClk,
  input  logic                rst,
  input  logic [N_AGENTS-1:0] req,
  output logic [N_AGENTS-1:0] gnt,
  output logic                busy,
  output logic [ID_W-1:0]     cur_id,
  output logic [CNT_W-1:0]    q_count,
  output logic                timeout
);

  arb_state_t          state, state_nxt;
  logic [N_AGENTS-1:0] req_q, pend, arrival;
  logic [N_AGENTS-1:0] arr_new, cand, push_mask, rel_mask;
  logic [N_AGENTS-1:0] gnt_nxt;
  logic [ID_W-1:0]     cur_id_nxt, push_id, head_id, rel_id;
  logic                push_vld, fifo_push, fifo_pop, fifo_full, fifo_empty, rel_vld;

`ifdef CCB_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout_q, timeout_nxt;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy = |gnt;

  // Pending agents cannot re-arrive, so at most one entry per agent is ever queued.
  always_comb begin
    arr_new   = req & ~req_q & ~pend;
    cand      = arrival | arr_new;
    push_vld  = 1'b0;
    push_id   = '0;
    push_mask = '0;
    for (int i = N_AGENTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        push_vld     = 1'b1;
        push_id      = ID_W'(i);
        push_mask    = '0;
        push_mask[i] = 1'b1;
      end
    end
  end

  assign fifo_push = push_vld & ~fifo_full;

  ccb_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk       (fastClk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_id),
    .pop       (fifo_pop),
    .pop_data  (head_id),
    .count     (q_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    cur_id_nxt = cur_id;
    fifo_pop   = 1'b0;
    rel_vld    = 1'b0;
    rel_id     = cur_id;
`ifdef CCB_ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (req[head_id]) begin
            gnt_nxt          = '0;
            gnt_nxt[head_id] = 1'b1;
            cur_id_nxt       = head_id;
            state_nxt        = GRANT;
`ifdef CCB_ARB_TIMEOUT_EN
            hold_nxt = '0;
`endif
          end else begin
            rel_vld = 1'b1;
            rel_id  = head_id;
          end
        end
      end
      GRANT: begin
        if (!req[cur_id]) begin
          gnt_nxt    = '0;
          cur_id_nxt = '0;
          rel_vld    = 1'b1;
          state_nxt  = IDLE;
        end
`ifdef CCB_ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          gnt_nxt     = '0;
          cur_id_nxt  = '0;
          rel_vld     = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    rel_mask = '0;
    if (rel_vld) rel_mask[rel_id] = 1'b1;
  end

  always_ff @(posedge fastClk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      cur_id  <= '0;
      req_q   <= req;
      pend    <= '0;
      arrival <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      cur_id  <= cur_id_nxt;
      req_q   <= req;
      pend    <= (pend | (fifo_push ? push_mask : '0)) & ~rel_mask;
      arrival <= cand & ~(fifo_push ? push_mask : '0);
    end
  end

`ifdef CCB_ARB_TIMEOUT_EN
  always_ff @(posedge fastClk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_nxt;
      timeout_q <= timeout_nxt;
    end
  end
`endif

endmodule
